// File: rtl/instr_fetch.sv
// rtl/instr_fetch.sv - IF stage: PC, IF/ID register, redirect, halt; boot-loader under INSTR_FETCH_BOOTLOAD_EN.
module instr_fetch #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] HALT_WORD = 32'hFFFF_FFFF
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_rdata,
    output logic [31:0] imem_wdata,
    output logic        imem_write,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    input  logic        id_ready,
    output logic        id_valid,
    output logic [31:0] id_instr,
    output logic [31:0] id_pc,
    output logic        halted
`ifdef INSTR_FETCH_BOOTLOAD_EN
    ,
    input  logic        load_valid,
    input  logic [31:0] load_data,
    input  logic        load_last
`endif
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_LOAD = 2'd1,
        S_RUN  = 2'd2,
        S_HALT = 2'd3
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic        id_valid_q, id_valid_d;
    logic [31:0] id_instr_q, id_instr_d;
    logic [31:0] id_pc_q, id_pc_d;

    logic [31:0] redirect_tgt;
    logic        capture_en;
    logic        unused_redirect_lsbs;

    assign redirect_tgt         = {redirect_pc[31:2], 2'b00};
    assign unused_redirect_lsbs = ^redirect_pc[1:0];
    // The IF/ID slot can take a new word when empty or being drained this cycle.
    assign capture_en           = !id_valid_q || id_ready;

`ifdef INSTR_FETCH_BOOTLOAD_EN
    logic [31:0] load_ptr_q, load_ptr_d;

    always_comb begin
        load_ptr_d = load_ptr_q;
        if (state_q == S_LOAD && load_valid) begin
            load_ptr_d = load_last ? 32'h0 : load_ptr_q + 32'd4;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            load_ptr_q <= 32'h0;
        end else begin
            load_ptr_q <= load_ptr_d;
        end
    end

    assign imem_addr  = (state_q == S_LOAD) ? load_ptr_q : pc_q;
    assign imem_write = (state_q == S_LOAD) && load_valid;
    assign imem_wdata = (state_q == S_LOAD) ? load_data : 32'h0;
`else
    assign imem_addr  = pc_q;
    assign imem_write = 1'b0;
    assign imem_wdata = 32'h0;
`endif

    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        id_valid_d = id_valid_q;
        id_instr_d = id_instr_q;
        id_pc_d    = id_pc_q;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    pc_d = RESET_PC;
`ifdef INSTR_FETCH_BOOTLOAD_EN
                    state_d = S_LOAD;
`else
                    state_d = S_RUN;
`endif
                end
            end

            S_LOAD: begin
`ifdef INSTR_FETCH_BOOTLOAD_EN
                if (load_valid && load_last) begin
                    state_d = S_RUN;
                    pc_d    = RESET_PC;
                end
`else
                state_d = S_IDLE;
`endif
            end

            S_RUN: begin
                if (redirect_valid) begin
                    pc_d       = redirect_tgt;
                    id_valid_d = 1'b0;
                end else if (capture_en) begin
                    id_instr_d = imem_rdata;
                    id_pc_d    = pc_q;
                    id_valid_d = 1'b1;
                    // The halt word is still handed to decode; fetching stops behind it.
                    if (imem_rdata == HALT_WORD) begin
                        state_d = S_HALT;
                    end else begin
                        pc_d = pc_q + 32'd4;
                    end
                end
            end

            S_HALT: begin
                if (redirect_valid) begin
                    pc_d       = redirect_tgt;
                    id_valid_d = 1'b0;
                    state_d    = S_RUN;
                end else if (id_valid_q && id_ready) begin
                    id_valid_d = 1'b0;
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            pc_q       <= RESET_PC;
            id_valid_q <= 1'b0;
            id_instr_q <= 32'h0;
            id_pc_q    <= 32'h0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            id_valid_q <= id_valid_d;
            id_instr_q <= id_instr_d;
            id_pc_q    <= id_pc_d;
        end
    end

    assign id_valid = id_valid_q;
    assign id_instr = id_instr_q;
    assign id_pc    = id_pc_q;
    assign halted   = (state_q == S_HALT);

endmodule

// File: tb/tb_instr_fetch.sv
// tb/tb_instr_fetch.sv - self-checking bench for instr_fetch (optional INSTR_FETCH_BOOTLOAD_EN section).
module tb_instr_fetch;

    localparam logic [31:0] HALT_W = 32'hFFFF_FFFF;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [31:0] imem_addr;
    logic [31:0] imem_rdata;
    logic [31:0] imem_wdata;
    logic        imem_write;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        id_ready;
    logic        id_valid;
    logic [31:0] id_instr;
    logic [31:0] id_pc;
    logic        halted;
`ifdef INSTR_FETCH_BOOTLOAD_EN
    logic        load_valid;
    logic [31:0] load_data;
    logic        load_last;
`endif

    logic [31:0] mem [32];
    int n_cmp = 0;
    int n_fail = 0;

    instr_fetch dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .start          (start),
        .imem_addr      (imem_addr),
        .imem_rdata     (imem_rdata),
        .imem_wdata     (imem_wdata),
        .imem_write     (imem_write),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .id_ready       (id_ready),
        .id_valid       (id_valid),
        .id_instr       (id_instr),
        .id_pc          (id_pc),
        .halted         (halted)
`ifdef INSTR_FETCH_BOOTLOAD_EN
        ,
        .load_valid     (load_valid),
        .load_data      (load_data),
        .load_last      (load_last)
`endif
    );

    assign imem_rdata = mem[imem_addr[6:2]];

    always #5 clk = ~clk;

    typedef struct {
        logic        ready;
        logic        redir;
        logic [31:0] rpc;
        logic        exp_valid;
        logic [31:0] exp_pc;
        logic [31:0] exp_addr;
    } vec_t;

    vec_t vecs [10];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Memory write is sampled just before the edge, as the real memory would at posedge.
    task automatic tick();
        if (imem_write === 1'b1) mem[imem_addr[6:2]] = imem_wdata;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        start = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc = 32'h0;
        id_ready = 1'b0;
`ifdef INSTR_FETCH_BOOTLOAD_EN
        load_valid = 1'b0;
        load_data = 32'h0;
        load_last = 1'b0;
`endif
        tick();
        tick();
        rst_n = 1'b1;
        tick();
    endtask

    task automatic do_start();
        start = 1'b1;
        tick();
        start = 1'b0;
`ifdef INSTR_FETCH_BOOTLOAD_EN
        load_valid = 1'b1;
        load_last = 1'b1;
        load_data = mem[0];
        tick();
        load_valid = 1'b0;
        load_last = 1'b0;
`endif
    endtask

    task automatic chk_reset_values(input string tag);
        chk({tag, "_addr"}, imem_addr, 32'h0);
        chk({tag, "_valid"}, {31'h0, id_valid}, 32'h0);
        chk({tag, "_instr"}, id_instr, 32'h0);
        chk({tag, "_pc"}, id_pc, 32'h0);
        chk({tag, "_halted"}, {31'h0, halted}, 32'h0);
        chk({tag, "_wr"}, {31'h0, imem_write}, 32'h0);
        chk({tag, "_wdata"}, imem_wdata, 32'h0);
    endtask

    initial begin
        logic [31:0] exp_pc;
        logic [31:0] old_instr;
        logic [31:0] old_pc;
        logic [31:0] tgt;
        logic        cur_valid;
        logic        r;
        logic        rd;
        int          ntx;

        for (int i = 0; i < 32; i++) mem[i] = 32'hA000_0000 | (i * 32'h0101);

        // Fetch, 3-cycle stall on B, then redirect to 0x15 with id_ready high.
        vecs[0] = '{1'b1, 1'b0, 32'h0,  1'b1, 32'h00, 32'h04};
        vecs[1] = '{1'b1, 1'b0, 32'h0,  1'b1, 32'h04, 32'h08};
        vecs[2] = '{1'b0, 1'b0, 32'h0,  1'b1, 32'h04, 32'h08};
        vecs[3] = '{1'b0, 1'b0, 32'h0,  1'b1, 32'h04, 32'h08};
        vecs[4] = '{1'b0, 1'b0, 32'h0,  1'b1, 32'h04, 32'h08};
        vecs[5] = '{1'b1, 1'b0, 32'h0,  1'b1, 32'h08, 32'h0C};
        vecs[6] = '{1'b1, 1'b0, 32'h0,  1'b1, 32'h0C, 32'h10};
        vecs[7] = '{1'b1, 1'b1, 32'h15, 1'b0, 32'h0C, 32'h14};
        vecs[8] = '{1'b1, 1'b0, 32'h0,  1'b1, 32'h14, 32'h18};
        vecs[9] = '{1'b1, 1'b0, 32'h0,  1'b1, 32'h18, 32'h1C};

        rst_n = 1'b0;
        start = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc = 32'h0;
        id_ready = 1'b0;
`ifdef INSTR_FETCH_BOOTLOAD_EN
        load_valid = 1'b0;
        load_data = 32'h0;
        load_last = 1'b0;
`endif
        #2;
        chk_reset_values("reset");

        do_reset();
        do_start();
        chk("start_valid", {31'h0, id_valid}, 32'h0);
        chk("start_addr", imem_addr, 32'h0);
        for (int i = 0; i < 10; i++) begin
            id_ready = vecs[i].ready;
            redirect_valid = vecs[i].redir;
            redirect_pc = vecs[i].rpc;
            tick();
            chk($sformatf("vec%0d_valid", i), {31'h0, id_valid}, {31'h0, vecs[i].exp_valid});
            chk($sformatf("vec%0d_addr", i), imem_addr, vecs[i].exp_addr);
            if (vecs[i].exp_valid) begin
                chk($sformatf("vec%0d_pc", i), id_pc, vecs[i].exp_pc);
                chk($sformatf("vec%0d_instr", i), id_instr, mem[vecs[i].exp_pc[6:2]]);
            end
        end
        redirect_valid = 1'b0;

        // Halt word at address 8, then redirect back to 0.
        do_reset();
        mem[2] = HALT_W;
        do_start();
        id_ready = 1'b1;
        tick();
        chk("halt_a_pc", id_pc, 32'h0);
        tick();
        chk("halt_b_pc", id_pc, 32'h4);
        tick();
        chk("halt_word", id_instr, HALT_W);
        chk("halt_word_pc", id_pc, 32'h8);
        chk("halt_word_valid", {31'h0, id_valid}, 32'h1);
        chk("halt_flag", {31'h0, halted}, 32'h1);
        chk("halt_addr", imem_addr, 32'h8);
        tick();
        chk("halt_drained", {31'h0, id_valid}, 32'h0);
        tick();
        chk("halt_no_fetch", {31'h0, id_valid}, 32'h0);
        chk("halt_still", {31'h0, halted}, 32'h1);
        redirect_valid = 1'b1;
        redirect_pc = 32'h0;
        tick();
        redirect_valid = 1'b0;
        chk("resume_halted", {31'h0, halted}, 32'h0);
        chk("resume_addr", imem_addr, 32'h0);
        chk("resume_bubble", {31'h0, id_valid}, 32'h0);
        tick();
        chk("resume_valid", {31'h0, id_valid}, 32'h1);
        chk("resume_pc", id_pc, 32'h0);
        chk("resume_instr", id_instr, mem[0]);
        mem[2] = 32'hA000_0202;

        // Asynchronous reset in the middle of a stall.
        do_reset();
        do_start();
        id_ready = 1'b1;
        tick();
        id_ready = 1'b0;
        tick();
        tick();
        chk("prereset_valid", {31'h0, id_valid}, 32'h1);
        #2;
        rst_n = 1'b0;
        #1;
        chk_reset_values("async_rst");
        tick();
        rst_n = 1'b1;
        tick();
        do_start();
        id_ready = 1'b1;
        tick();
        chk("post_rst_valid", {31'h0, id_valid}, 32'h1);
        chk("post_rst_pc", id_pc, 32'h0);
        chk("post_rst_instr", id_instr, mem[0]);

`ifdef INSTR_FETCH_BOOTLOAD_EN
        // Boot-load three words, then fetch them back from address 0.
        do_reset();
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int k = 0; k < 3; k++) begin
            load_valid = 1'b1;
            load_data = 32'hB0B0_0000 + k;
            load_last = (k == 2);
            #1;
            chk($sformatf("load%0d_addr", k), imem_addr, k * 4);
            chk($sformatf("load%0d_wr", k), {31'h0, imem_write}, 32'h1);
            tick();
        end
        load_valid = 1'b0;
        load_last = 1'b0;
        id_ready = 1'b1;
        for (int k = 0; k < 3; k++) begin
            tick();
            chk($sformatf("boot%0d_pc", k), id_pc, k * 4);
            chk($sformatf("boot%0d_instr", k), id_instr, 32'hB0B0_0000 + k);
        end
`endif

        // Randomized run against a delivered-stream scoreboard.
        do_reset();
        for (int i = 0; i < 32; i++) begin
            mem[i] = $urandom;
            if (mem[i] == HALT_W) mem[i] = 32'h1234_5678;
        end
        do_start();
        exp_pc = 32'h0;
        ntx = 0;
        for (int c = 0; c < 3000; c++) begin
            cur_valid = id_valid;
            r = ($urandom_range(0, 3) != 0);
            rd = ($urandom_range(0, 15) == 0);
            tgt = $urandom;
            if (cur_valid && r && !rd) begin
                chk("rand_pc", id_pc, exp_pc);
                chk("rand_instr", id_instr, mem[exp_pc[6:2]]);
                exp_pc = exp_pc + 32'd4;
                ntx++;
            end
            if (rd) exp_pc = {tgt[31:2], 2'b00};
            old_instr = id_instr;
            old_pc = id_pc;
            id_ready = r;
            redirect_valid = rd;
            redirect_pc = tgt;
            tick();
            if (rd) begin
                chk("rand_flush", {31'h0, id_valid}, 32'h0);
                chk("rand_tgt_addr", imem_addr, {tgt[31:2], 2'b00});
            end else if (cur_valid && !r) begin
                chk("rand_stall_valid", {31'h0, id_valid}, 32'h1);
                chk("rand_stall_instr", id_instr, old_instr);
                chk("rand_stall_pc", id_pc, old_pc);
            end
            chk("rand_halted", {31'h0, halted}, 32'h0);
            chk("rand_wr", {31'h0, imem_write}, 32'h0);
        end
        redirect_valid = 1'b0;
        chk("rand_throughput", {31'h0, ntx > 1200}, 32'h1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/instr_fetch.md
# instr_fetch

Instruction fetch stage sitting directly upstream of the word-addressed instruction memory. It owns the program counter and drives the memory address. It captures the combinationally-read instruction into an IF/ID register and hands it to decode over a valid/ready handshake. It also handles branch/jump redirects, halt detection and, optionally, boot-loading program words into the memory.

## Interface
- RESET_PC, 32'h0000_0000, PC value loaded at reset and at the start of RUN.
- HALT_WORD, 32'hFFFF_FFFF, instruction encoding that stops fetching.
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous, active-low reset.
- start  in  1  leaves IDLE; one-cycle pulse, ignored outside IDLE.
- imem_addr  out  32  byte address to memory; memory uses bits [6:2] for 32 words.
- imem_rdata  in  32  combinational read data for imem_addr.
- imem_wdata  out  32  write data to memory.
- imem_write  out  1  memory write strobe, sampled by memory at posedge clk.
- redirect_valid  in  1  branch/jump taken; load redirect_pc and flush.
- redirect_pc  in  32  target byte address; bits [1:0] ignored (forced 0).
- id_ready  in  1  decode accepts id_instr this cycle.
- id_valid  out  1  IF/ID register holds a valid instruction.
- id_instr  out  32  fetched instruction.
- id_pc  out  32  address of id_instr.
- halted  out  1  high in HALT state.
- load_valid, load_data[31:0], load_last  in  1/32/1  boot-load stream (INSTR_FETCH_BOOTLOAD_EN only).

## Operation
- States: IDLE, LOAD (macro only), RUN, HALT. Reset -> IDLE.
- IDLE: no fetch, id_valid=0. start -> LOAD (macro) or RUN (no macro); pc <= RESET_PC.
- RUN: imem_addr = pc. At each posedge where (!id_valid || id_ready), the unit captures id_instr <= imem_rdata and id_pc <= pc, sets id_valid <= 1, and advances pc <= pc+4 (mod 2^32; the memory aliases every 128 bytes, which is acceptable). Otherwise it holds pc and the IF/ID contents (stall).
- Halt: a captured instruction equal to HALT_WORD is delivered normally. pc is not incremented and the state goes to HALT. In HALT, no new capture occurs; id_valid clears once that word is accepted.
- Redirect (RUN or HALT): pc <= {redirect_pc[31:2],2'b00} and id_valid <= 0. The held instruction is discarded even when id_ready=1 in the same cycle. From HALT, the state returns to RUN. Redirect is ignored in IDLE and LOAD.
- imem_write=0 and imem_wdata=0 whenever not in LOAD.

## Timing
- Reset values: state IDLE, pc=RESET_PC, imem_addr=RESET_PC, id_valid=0, id_instr=0, id_pc=0, halted=0, imem_write=0, imem_wdata=0.
- Fetch latency: instruction at pc appears on id_instr one cycle after pc is presented. Throughput is 1 instr/cycle with id_ready held high.
- Handshake: a transfer occurs on the edge where id_valid && id_ready. id_instr and id_pc are stable while id_valid && !id_ready.
- Redirect: the target is on imem_addr the cycle after redirect_valid. The target instruction is valid on id_instr one cycle later. That gives one bubble plus a flush.
- Reset asserted mid-operation clears state immediately and asynchronously. Memory contents are unaffected, and any in-progress load is abandoned.

## Configuration
- INSTR_FETCH_BOOTLOAD_EN defined:
  - load_* ports exist and IDLE+start -> LOAD. In LOAD, imem_addr = load_ptr (reset 0), imem_write = load_valid and imem_wdata = load_data, all combinational.
  - Each load_valid cycle advances load_ptr by 4. load_valid && load_last -> RUN with pc=RESET_PC and load_ptr=0.
  - Words past 32 wrap over earlier words.
- Undefined: the load ports are absent, imem_write and imem_wdata are tied to 0, and start goes IDLE -> RUN directly.

## Test plan
- Reset then start with id_ready=1 and memory words 0..3 = A,B,C,D -> id_instr A,B,C,D with id_pc 0,4,8,C on consecutive cycles.
- Hold id_ready=0 for 3 cycles while B is valid -> id_instr=B and id_pc=4 stable, pc stays 8. On release, C follows next cycle.
- Redirect to 0x15 while id_ready=1 -> id_valid=0 next cycle, imem_addr=0x14, then id_pc=0x14.
- Word 2 = 32'hFFFF_FFFF -> delivered with id_pc=8, halted=1, no further id_valid. A redirect to 0 resumes RUN and delivers A.
- Deassert rst_n mid-stall -> all outputs at reset values immediately; after start, fetch resumes from RESET_PC.
- Bootload with macro: stream 3 words with load_last on the third -> memory words 0..2 written, then fetch delivers them from pc 0.
